// File: rtl/bip_control.sv
// ----------------------------------------------------------------------------
// bip_control
//
// Control unit for the BIP1 accumulator processor.
//   - Keeps the program counter and fetches 16-bit instructions from a
//     synchronous-read program memory (data returns one clock after the
//     address is presented).
//   - Decodes the opcode and drives the accumulator datapath selects, the
//     accumulator write enable, the ALU operation and the data-memory strobes.
//   - Run/halt control plus a cycle counter for the debug unit.
//
// Sequencing: IDLE -> FETCH -> EXEC [-> WB] -> FETCH ... -> HALT
//   Immediate / STO / NOP : FETCH, EXEC          (2 clocks)
//   LD / ADD / SUB        : FETCH, EXEC, WB      (3 clocks)
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset        asynchronous, active-low reset
//   i_start        start pulse, honoured only in IDLE or HALT
//   i_instruction  program memory read data, valid one clock after o_pc_addr
//   o_pc_addr      program memory address (current PC)
//   o_selA         accumulator input select: 00 data mem, 01 operand, 10 ALU
//   o_selB         ALU B select: 0 data memory, 1 operand
//   o_WrAcc        accumulator write enable
//   o_Op           ALU op: 0 add, 1 sub
//   o_Operand      operand field to datapath / data memory address
//   o_RdRam        data memory read strobe
//   o_WrRam        data memory write strobe (stores accumulator)
//   o_done         high while in HALT
//   o_illegal      illegal opcode flag (only ever set when the trap is built)
//   o_cycle_count  clocks spent in FETCH/EXEC/WB since the last start
//
// Build option
//   BIP_ILLEGAL_TRAP_EN  when defined, an undefined opcode halts the machine
//                        with o_illegal=1 and the PC left on the offending
//                        instruction. When undefined, such opcodes are NOPs and
//                        o_illegal stays 0.
// ----------------------------------------------------------------------------
module bip_control #(
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_ADDR    = 11,
  parameter int NB_COUNT   = 32
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [NB_OPCODE+NB_OPERAND-1:0] i_instruction,
  output logic [NB_ADDR-1:0]              o_pc_addr,
  output logic [1:0]                      o_selA,
  output logic                            o_selB,
  output logic                            o_WrAcc,
  output logic                            o_Op,
  output logic [NB_OPERAND-1:0]           o_Operand,
  output logic                            o_RdRam,
  output logic                            o_WrRam,
  output logic                            o_done,
  output logic                            o_illegal,
  output logic [NB_COUNT-1:0]             o_cycle_count
);

  localparam int NB_INSTR = NB_OPCODE + NB_OPERAND;

  // Opcode map
  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

  // Accumulator input select encodings
  localparam logic [1:0] SEL_RAM     = 2'b00;
  localparam logic [1:0] SEL_OPERAND = 2'b01;
  localparam logic [1:0] SEL_ALU     = 2'b10;

  localparam logic [NB_ADDR-1:0]  PC_ONE  = NB_ADDR'(1);
  localparam logic [NB_COUNT-1:0] CNT_ONE = NB_COUNT'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic [NB_ADDR-1:0]    pc_q,    pc_d;
  logic [NB_INSTR-1:0]   ir_q,    ir_d;
  logic [NB_COUNT-1:0]   count_q, count_d;
  logic                  illegal_q, illegal_d;

  logic [NB_OPCODE-1:0]  exec_opcode;
  logic [NB_OPCODE-1:0]  wb_opcode;
  logic                  count_en;

  // EXEC decodes the word arriving from program memory this cycle; WB decodes
  // the copy latched into IR at the end of EXEC.
  assign exec_opcode = i_instruction[NB_INSTR-1 -: NB_OPCODE];
  assign wb_opcode   = ir_q[NB_INSTR-1 -: NB_OPCODE];

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    count_d   = count_q;
    illegal_d = illegal_q;

    o_selA    = SEL_RAM;
    o_selB    = 1'b0;
    o_WrAcc   = 1'b0;
    o_Op      = 1'b0;
    o_RdRam   = 1'b0;
    o_WrRam   = 1'b0;
    o_Operand = ir_q[NB_OPERAND-1:0];

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          count_d = '0;
        end
      end

      S_FETCH: begin
        // o_pc_addr is already presenting the PC; the word comes back in EXEC.
        state_d = S_EXEC;
      end

      S_EXEC: begin
        ir_d      = i_instruction;
        o_Operand = i_instruction[NB_OPERAND-1:0];
        state_d   = S_FETCH;
        pc_d      = pc_q + PC_ONE;
        case (exec_opcode)
          OP_HLT: begin
            // PC stays on the HLT so the debugger sees where the program ended.
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          OP_STO: begin
            o_WrRam = 1'b1;
          end
          OP_LD, OP_ADD, OP_SUB: begin
            // Memory operand: read now, write the accumulator in WB.
            o_RdRam = 1'b1;
            state_d = S_WB;
            pc_d    = pc_q;
          end
          OP_LDI: begin
            o_selA  = SEL_OPERAND;
            o_WrAcc = 1'b1;
          end
          OP_ADDI: begin
            o_selA  = SEL_ALU;
            o_selB  = 1'b1;
            o_WrAcc = 1'b1;
          end
          OP_SUBI: begin
            o_selA  = SEL_ALU;
            o_selB  = 1'b1;
            o_Op    = 1'b1;
            o_WrAcc = 1'b1;
          end
          default: begin
`ifdef BIP_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            pc_d      = pc_q;
            illegal_d = 1'b1;
`else
            // Undefined opcode: NOP, PC already advancing.
`endif
          end
        endcase
      end

      S_WB: begin
        // Only LD/ADD/SUB reach WB; the data-memory word is on the datapath.
        o_WrAcc = 1'b1;
        pc_d    = pc_q + PC_ONE;
        state_d = S_FETCH;
        case (wb_opcode)
          OP_ADD: begin
            o_selA = SEL_ALU;
          end
          OP_SUB: begin
            o_selA = SEL_ALU;
            o_Op   = 1'b1;
          end
          default: begin
            o_selA = SEL_RAM;
          end
        endcase
      end

      S_HALT: begin
        if (i_start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          count_d   = '0;
          illegal_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The counter runs on every clock that stays inside FETCH/EXEC/WB; the
    // edge that retires the program into HALT is not counted, so a HLT costs
    // one counted clock (its FETCH).
    count_en = ((state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WB))
               && (state_d != S_HALT);
    if (count_en) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: IR is reset as well, so o_Operand is a defined 0 out of reset
      // rather than whatever the flops power up with.
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_pc_addr     = pc_q;
  assign o_done        = (state_q == S_HALT);
  assign o_cycle_count = count_q;

`ifdef BIP_ILLEGAL_TRAP_EN
  assign o_illegal = illegal_q;
`else
  // Without the trap nothing ever sets illegal_q; the flag is a constant 0.
  assign o_illegal = 1'b0 & illegal_q;
`endif

endmodule
